// File: rtl/cordic_hyp_pkg.sv
// rtl/cordic_hyp_pkg.sv - shared constants and shift schedule for the hyperbolic CORDIC pipeline
package cordic_hyp_pkg;

  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  // Hyperbolic gain of the full schedule and its reciprocal, Q2.30
  localparam int KH_Q30     = 889229343;
  localparam int INV_KH_Q30 = 1296540104;

  // atanh(2^-s) in Q2.30, truncated; beyond s = 9 the value is 2^-s to within an LSB
  function automatic logic [31:0] atanh_q30(input int s);
    logic [31:0] v;
    case (s)
      1:       v = 32'd589812981;
      2:       v = 32'd274247418;
      3:       v = 32'd134923406;
      4:       v = 32'd67196450;
      5:       v = 32'd33565361;
      6:       v = 32'd16778581;
      7:       v = 32'd8388778;
      8:       v = 32'd4194325;
      9:       v = 32'd2097154;
      default: v = (s >= 10 && s <= 30) ? (32'd1 << (30 - s)) : 32'd0;
    endcase
    return v;
  endfunction

  // Shifts 4, 13 and 40 are applied twice so the hyperbolic iteration converges
  function automatic int stage_shift(input int idx);
    int   s;
    logic rep;
    s   = 1;
    rep = 1'b0;
    for (int j = 0; j < idx; j++) begin
      if ((s == 4 || s == 13 || s == 40) && !rep) begin
        rep = 1'b1;
      end else begin
        s   = s + 1;
        rep = 1'b0;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/cordic_hyp_stage.sv
// rtl/cordic_hyp_stage.sv - one hyperbolic micro-rotation with registered result and enable
module cordic_hyp_stage
  import cordic_hyp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z
);

  localparam logic [31:0]      ANG_Q30 = atanh_q30(SHIFT);
  localparam logic [WIDTH-1:0] ANG     = WIDTH'(ANG_Q30 >> (30 - FRAC));

  logic             valid_d, valid_q;
  logic             mode_d, mode_q;
  logic [WIDTH-1:0] x_d, x_q, y_d, y_q, z_d, z_q;
  logic [WIDTH-1:0] x_sh, y_sh;
  logic             dir_pos;

  always_comb begin
    x_sh    = $signed(in_x) >>> SHIFT;
    y_sh    = $signed(in_y) >>> SHIFT;
    dir_pos = (in_mode == MODE_ROT) ? ~in_z[WIDTH-1] : in_y[WIDTH-1];
    valid_d = valid_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    if (en) begin
      valid_d = in_valid;
      mode_d  = in_mode;
      x_d     = dir_pos ? in_x + y_sh : in_x - y_sh;
      y_d     = dir_pos ? in_y + x_sh : in_y - x_sh;
      z_d     = dir_pos ? in_z - ANG  : in_z + ANG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    x_q    <= x_d;
    y_q    <= y_d;
    z_q    <= z_d;
  end

  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;

endmodule

// File: rtl/cordic_hyp_pipe.sv
// rtl/cordic_hyp_pipe.sv - parametrised hyperbolic CORDIC pipeline with valid/ready and global stall
module cordic_hyp_pipe
  import cordic_hyp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int NSTG  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z
);

  logic             advance;
  logic             stg_valid [NSTG+1];
  logic             stg_mode  [NSTG+1];
  logic [WIDTH-1:0] stg_x     [NSTG+1];
  logic [WIDTH-1:0] stg_y     [NSTG+1];
  logic [WIDTH-1:0] stg_z     [NSTG+1];

  logic             in_valid_d, in_valid_q, in_mode_d, in_mode_q;
  logic [WIDTH-1:0] in_x_d, in_x_q, in_y_d, in_y_q, in_z_d, in_z_q;
  logic             out_valid_d, out_valid_q, out_mode_d, out_mode_q;
  logic [WIDTH-1:0] out_x_d, out_x_q, out_y_d, out_y_q, out_z_d, out_z_q;

  // Whole pipe moves together; only a held, unaccepted result blocks it
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    in_valid_d  = advance ? in_valid        : in_valid_q;
    in_mode_d   = advance ? in_mode         : in_mode_q;
    in_x_d      = advance ? in_x            : in_x_q;
    in_y_d      = advance ? in_y            : in_y_q;
    in_z_d      = advance ? in_z            : in_z_q;
    out_valid_d = advance ? stg_valid[NSTG] : out_valid_q;
    out_mode_d  = advance ? stg_mode[NSTG]  : out_mode_q;
    out_x_d     = advance ? stg_x[NSTG]     : out_x_q;
    out_y_d     = advance ? stg_y[NSTG]     : out_y_q;
    out_z_d     = advance ? stg_z[NSTG]     : out_z_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
    end else begin
      in_valid_q  <= in_valid_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
    end
  end

  always_ff @(posedge clk) begin
    in_mode_q <= in_mode_d;
    in_x_q    <= in_x_d;
    in_y_q    <= in_y_d;
    in_z_q    <= in_z_d;
  end

  assign stg_valid[0] = in_valid_q;
  assign stg_mode[0]  = in_mode_q;
  assign stg_x[0]     = in_x_q;
  assign stg_y[0]     = in_y_q;
  assign stg_z[0]     = in_z_q;

  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    cordic_hyp_stage #(
      .WIDTH(WIDTH),
      .FRAC (FRAC),
      .SHIFT(stage_shift(i))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (advance),
      .in_valid (stg_valid[i]),
      .in_mode  (stg_mode[i]),
      .in_x     (stg_x[i]),
      .in_y     (stg_y[i]),
      .in_z     (stg_z[i]),
      .out_valid(stg_valid[i+1]),
      .out_mode (stg_mode[i+1]),
      .out_x    (stg_x[i+1]),
      .out_y    (stg_y[i+1]),
      .out_z    (stg_z[i+1])
    );
  end

  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;

endmodule

// File: tb/tb_cordic_hyp_pipe.sv
// tb/tb_cordic_hyp_pipe.sv - self-checking bench for cordic_hyp_pipe
module tb_cordic_hyp_pipe;

  localparam int W  = 16;
  localparam int F  = 12;
  localparam int N  = 16;
  localparam int W2 = 24;
  localparam int F2 = 20;
  localparam int N2 = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [W-1:0]  in_x, in_y, in_z, out_x, out_y, out_z;
  logic          s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_mode;
  logic [W2-1:0] s_in_x, s_in_y, s_in_z, s_out_x, s_out_y, s_out_z;

  cordic_hyp_pipe #(.WIDTH(W), .FRAC(F), .NSTG(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  cordic_hyp_pipe #(.WIDTH(W2), .FRAC(F2), .NSTG(N2)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode),
    .in_x(s_in_x), .in_y(s_in_y), .in_z(s_in_z), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_mode(s_out_mode), .out_x(s_out_x), .out_y(s_out_y), .out_z(s_out_z)
  );

  typedef struct {
    logic   mode;
    longint x;
    longint y;
    longint z;
  } res_t;

  res_t   exp_q[$];
  res_t   cmp_e;
  int     checks = 0;
  int     errors = 0;
  int     got_cnt = 0;
  int     consec = 0;
  int     max_run = 0;
  int     stall_cnt = 0;

  task automatic chk(input string name, input longint act, input longint expv, input longint tol);
    checks++;
    if (act - expv > tol || expv - act > tol) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, expv, tol);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic int sched(input int i);
    int q[$];
    for (int k = 1; q.size() <= i; k++) begin
      q.push_back(k);
      if (k == 4 || k == 13 || k == 40) q.push_back(k);
    end
    return q[i];
  endfunction

  function automatic real atanh_r(input real t);
    real p, s;
    p = t;
    s = 0.0;
    for (int k = 0; k < 40; k++) begin
      s = s + p / real'(2 * k + 1);
      p = p * t * t;
    end
    return s;
  endfunction

  function automatic longint ang_tab(input int s, input int frac);
    real t, v;
    t = 1.0;
    repeat (s) t = t / 2.0;
    v = atanh_r(t);
    repeat (frac) v = v * 2.0;
    return longint'($floor(v));
  endfunction

  function automatic real kh_r(input int nstg);
    real k, t;
    k = 1.0;
    for (int i = 0; i < nstg; i++) begin
      t = 1.0;
      repeat (sched(i)) t = t / 2.0;
      k = k * $sqrt(1.0 - t * t);
    end
    return k;
  endfunction

  function automatic res_t cordic_model(input int w, input int frac, input int nstg, input logic mode,
                                        input longint x0, input longint y0, input longint z0);
    res_t   r;
    longint x, y, z, xs, ys, a;
    int     s;
    logic   up;
    x = wrap(x0, w);
    y = wrap(y0, w);
    z = wrap(z0, w);
    for (int i = 0; i < nstg; i++) begin
      s  = sched(i);
      a  = ang_tab(s, frac);
      up = mode ? (z >= 0) : (y < 0);
      xs = x >>> s;
      ys = y >>> s;
      if (up) begin
        x = wrap(x + ys, w);
        y = wrap(y + xs, w);
        z = wrap(z - a, w);
      end else begin
        x = wrap(x - ys, w);
        y = wrap(y - xs, w);
        z = wrap(z + a, w);
      end
    end
    r.mode = mode;
    r.x = x;
    r.y = y;
    r.z = z;
    return r;
  endfunction

  // Scoreboard: every accepted input becomes one expected result, checked in order
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", longint'(in_ready), longint'(!out_valid || out_ready), 0);
      if (out_valid && !out_ready) stall_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=valid required=none");
        end else begin
          cmp_e = exp_q[0];
          chk("sb_mode", longint'(out_mode), longint'(cmp_e.mode), 0);
          chk("sb_x", longint'($signed(out_x)), cmp_e.x, 0);
          chk("sb_y", longint'($signed(out_y)), cmp_e.y, 0);
          chk("sb_z", longint'($signed(out_z)), cmp_e.z, 0);
          if (out_ready) begin
            exp_q.delete(0);
            got_cnt++;
          end
        end
      end
      if (out_valid && out_ready) consec++;
      else consec = 0;
      if (consec > max_run) max_run = consec;
      if (in_valid && in_ready)
        exp_q.push_back(cordic_model(W, F, N, in_mode, longint'($signed(in_x)),
                                     longint'($signed(in_y)), longint'($signed(in_z))));
    end
  end

  task automatic run_main(input logic m, input longint x, input longint y, input longint z,
                          output int lat, output longint ox, output longint oy, output longint oz,
                          output logic om);
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = W'(x);
    in_y     = W'(y);
    in_z     = W'(z);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ox = longint'($signed(out_x));
    oy = longint'($signed(out_y));
    oz = longint'($signed(out_z));
    om = out_mode;
  endtask

  task automatic gen_sample(input int i, output logic m, output longint x, output longint y,
                            output longint z);
    longint ymax;
    m = logic'(i % 2);
    if (m) begin
      x = 4946;
      y = 0;
      z = longint'($urandom_range(0, 7372)) - 3686;
    end else begin
      x    = longint'($urandom_range(2048, 4096));
      ymax = x * 7 / 10;
      y    = longint'($urandom_range(0, 32'(2 * ymax))) - ymax;
      z    = longint'($urandom_range(0, 200)) - 100;
    end
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_empty", longint'(exp_q.size()), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat, g0, cnt;
    longint ox, oy, oz, xin;
    logic   om, m;
    longint x, y, z;
    res_t   pm;
    real    kh, cz, sz;
    logic   bm [20];
    longint bx [20], by [20], bz [20];
    int     idx, cyc;
    logic   acc;

    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_mode = 1'b0; s_in_x = '0; s_in_y = '0; s_in_z = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", longint'(out_valid), 0, 0);
    chk("reset_out_mode", longint'(out_mode), 0, 0);
    chk("reset_out_x", longint'(out_x), 0, 0);
    chk("reset_out_z", longint'(out_z), 0, 0);
    chk("reset_in_ready", longint'(in_ready), 1, 0);
    rst_n = 1'b1;

    // Pin the model against hand-computed constants
    chk("model_tab1", ang_tab(1, F), 2249, 0);
    chk("model_tab2", ang_tab(2, F), 1046, 0);
    chk("model_tab4", ang_tab(4, F), 256, 0);
    chk("model_kh", longint'($rtoi(kh_r(N) * 100000.0)), 82815, 1);
    pm = cordic_model(W, F, N, 1'b0, 4096, 2048, 0);
    chk("model_vec_z", pm.z, 2250, 3);

    repeat (2) @(posedge clk);
    #1;
    run_main(1'b0, 4096, 2048, 0, lat, ox, oy, oz, om);
    chk("vec_latency", lat, N + 1, 0);
    chk("vec_z", oz, 16'h08CA, 3);
    chk("vec_x", ox, 16'h0B7A, 3);
    chk("vec_y", oy, 0, 4);
    chk("vec_mode", longint'(om), 0, 0);

    repeat (3) @(posedge clk);
    #1;
    run_main(1'b1, 16'h1352, 0, 16'h0800, lat, ox, oy, oz, om);
    chk("rot_latency", lat, N + 1, 0);
    chk("rot_x", ox, 16'h120B, 3);
    chk("rot_y", oy, 16'h0857, 3);
    chk("rot_z", oz, 0, 3);
    chk("rot_mode", longint'(om), 1, 0);
    drain(50);

    g0 = got_cnt;
    max_run = 0;
    for (int i = 0; i < 40; i++) begin
      gen_sample(i, m, x, y, z);
      in_valid = 1'b1; in_mode = m; in_x = W'(x); in_y = W'(y); in_z = W'(z);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain(100);
    chk("stream_count", longint'(got_cnt - g0), 40, 0);
    chk("stream_back_to_back", longint'(max_run), 40, 0);

    for (int i = 0; i < 20; i++) begin
      gen_sample(i + 1, bm[i], bx[i], by[i], bz[i]);
    end
    g0 = got_cnt;
    stall_cnt = 0;
    idx = 0;
    cyc = 0;
    while (idx < 20 && cyc < 400) begin
      in_valid = 1'b1; in_mode = bm[idx];
      in_x = W'(bx[idx]); in_y = W'(by[idx]); in_z = W'(bz[idx]);
      out_ready = logic'($urandom_range(0, 1));
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", longint'(idx), 20, 0);
    drain(100);
    chk("bp_count", longint'(got_cnt - g0), 20, 0);
    checks++;
    if (stall_cnt == 0) begin
      errors++;
      $display("FAIL bp_stalls_seen actual=%0d required=nonzero", stall_cnt);
    end

    for (int i = 0; i < 20; i++) begin
      gen_sample(i, m, x, y, z);
      in_valid = 1'b1; in_mode = m; in_x = W'(x); in_y = W'(y); in_z = W'(z);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", longint'(out_valid), 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", longint'(out_valid), 0, 0);
    chk("async_rst_x", longint'(out_x), 0, 0);
    chk("async_rst_y", longint'(out_y), 0, 0);
    chk("async_rst_z", longint'(out_z), 0, 0);
    chk("async_rst_mode", longint'(out_mode), 0, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("no_stale_after_reset", longint'(cnt), 0, 0);
    run_main(1'b0, 3000, -1000, 0, lat, ox, oy, oz, om);
    chk("post_reset_latency", lat, N + 1, 0);
    drain(50);

    kh  = kh_r(N2);
    xin = longint'($rtoi(1048576.0 / kh + 0.5));
    cz  = ($exp(0.5) + $exp(-0.5)) / 2.0;
    sz  = ($exp(0.5) - $exp(-0.5)) / 2.0;
    s_in_valid = 1'b1; s_in_mode = 1'b1;
    s_in_x = W2'(xin); s_in_y = '0; s_in_z = 24'h080000;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    pm = cordic_model(W2, F2, N2, 1'b1, xin, 0, 24'h080000);
    chk("wide_latency", lat, N2 + 1, 0);
    chk("wide_cosh", longint'($signed(s_out_x)), longint'($rtoi(kh * real'(xin) * cz + 0.5)), 8);
    chk("wide_sinh", longint'($signed(s_out_y)), longint'($rtoi(kh * real'(xin) * sz + 0.5)), 8);
    chk("wide_z", longint'($signed(s_out_z)), 0, 8);
    chk("wide_model_x", longint'($signed(s_out_x)), pm.x, 0);
    chk("wide_model_y", longint'($signed(s_out_y)), pm.y, 0);
    chk("wide_mode", longint'(s_out_mode), 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
